// File: rtl/bpsk_pkg.sv
// Shared types and constants for the BPSK frame scheduler.
package bpsk_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Requester / owner encoding; also used as the index into the request vector
    localparam logic OWN_HOST = 1'b0;
    localparam logic OWN_BCN  = 1'b1;

    // Default frame geometry: 38 words of 32 bits
    localparam int WORD_BITS_DFLT   = 32;
    localparam int FRAME_BITS       = 38 * WORD_BITS_DFLT;
    localparam int SLOT_STRIDE_DFLT = 152;

endpackage

// File: rtl/bpsk_rr_arb.sv
// Two-way round-robin arbiter: grants the single requester directly, and on
// a tie grants the requester that did not win last time.
module bpsk_rr_arb
    import bpsk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic last_grant_reg;

    // Combinational one-hot grant, suppressed while the scheduler is busy
    always_comb begin
        grant = 2'b00;
        if (grant_en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant_reg == OWN_BCN) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Remember who won the most recent grant; beacon after reset so host wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= OWN_BCN;
        end else if (|grant) begin
            last_grant_reg <= grant[OWN_BCN];
        end
    end

    assign last_grant = last_grant_reg;

endmodule

// File: rtl/bpsk_frame_sched.sv
// Frame sequencer and arbiter that owns the BPSK modulator send_signal.
// Grants host or beacon, selects the BRAM slot base, and gates transmission
// for an exact number of baud bits per frame with repeat, gap and abort.
module bpsk_frame_sched
    import bpsk_pkg::*;
#(
    parameter int WORD_BITS   = WORD_BITS_DFLT,
    parameter int FRAME_WORDS = FRAME_BITS / WORD_BITS_DFLT,
    parameter int GAP_BITS    = 64,
    parameter int SLOT_STRIDE = SLOT_STRIDE_DFLT,
    parameter int ADDR_WIDTH  = 32,
    parameter int REP_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  baud_tick,
    input  logic                  host_req,
    input  logic                  host_slot,
    input  logic [REP_W-1:0]      host_repeat,
    input  logic                  bcn_req,
    input  logic                  bcn_slot,
    input  logic                  abort,
    output logic                  host_ack,
    output logic                  bcn_ack,
    output logic                  send_signal,
    output logic [ADDR_WIDTH-1:0] frame_base,
    output logic                  owner,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  aborted
);

    localparam int FRM_BITS = FRAME_WORDS * WORD_BITS;
    localparam int CNT_MAX  = (FRM_BITS > GAP_BITS) ? FRM_BITS : GAP_BITS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FRM_LAST = CNT_W'(FRM_BITS - 1);
    // Guarded so a zero-length gap does not produce a negative constant
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

    state_t                  state_reg;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic [REP_W-1:0]        rep_left_reg;
    logic                    send_reg;
    logic                    busy_reg;
    logic                    host_ack_reg;
    logic                    bcn_ack_reg;
    logic                    frame_done_reg;
    logic                    aborted_reg;
    logic [ADDR_WIDTH-1:0]   frame_base_reg;

    logic [1:0]              grant;
    logic                    last_grant;
    logic                    grant_slot;

    bpsk_rr_arb u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        ({bcn_req, host_req}),
        .grant_en   (state_reg == IDLE),
        .grant      (grant),
        .last_grant (last_grant)
    );

    assign grant_slot = grant[OWN_BCN] ? bcn_slot : host_slot;

    // Main scheduler FSM with all outputs registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            rep_left_reg   <= '0;
            send_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            host_ack_reg   <= 1'b0;
            bcn_ack_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            aborted_reg    <= 1'b0;
            frame_base_reg <= '0;
        end else begin
            host_ack_reg   <= 1'b0;
            bcn_ack_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            aborted_reg    <= 1'b0;

            if ((state_reg != IDLE) && abort) begin
                // Abort outranks everything, including a frame-completing tick
                state_reg    <= IDLE;
                send_reg     <= 1'b0;
                busy_reg     <= 1'b0;
                aborted_reg  <= 1'b1;
                rep_left_reg <= '0;
                bit_cnt_reg  <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (|grant) begin
                            state_reg      <= ARM;
                            busy_reg       <= 1'b1;
                            host_ack_reg   <= grant[OWN_HOST];
                            bcn_ack_reg    <= grant[OWN_BCN];
                            frame_base_reg <= grant_slot ? ADDR_WIDTH'(SLOT_STRIDE) : '0;
                            if (grant[OWN_BCN] || (host_repeat == '0))
                                rep_left_reg <= REP_W'(1);
                            else
                                rep_left_reg <= host_repeat;
                        end
                    end
                    ARM: begin
                        // Align the frame start to a fresh bit boundary
                        if (baud_tick) begin
                            state_reg   <= SEND;
                            send_reg    <= 1'b1;
                            bit_cnt_reg <= '0;
                        end
                    end
                    SEND: begin
                        if (baud_tick) begin
                            if (bit_cnt_reg == FRM_LAST) begin
                                frame_done_reg <= 1'b1;
                                rep_left_reg   <= rep_left_reg - REP_W'(1);
                                bit_cnt_reg    <= '0;
                                if (GAP_BITS != 0) begin
                                    state_reg <= GAP;
                                    send_reg  <= 1'b0;
                                end else if (rep_left_reg != REP_W'(1)) begin
                                    state_reg <= SEND;
                                    send_reg  <= 1'b1;
                                end else begin
                                    state_reg <= IDLE;
                                    send_reg  <= 1'b0;
                                    busy_reg  <= 1'b0;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (baud_tick) begin
                            if (bit_cnt_reg == GAP_LAST) begin
                                bit_cnt_reg <= '0;
                                if (rep_left_reg != '0) begin
                                    state_reg <= SEND;
                                    send_reg  <= 1'b1;
                                end else begin
                                    state_reg <= IDLE;
                                    busy_reg  <= 1'b0;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        send_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign host_ack    = host_ack_reg;
    assign bcn_ack     = bcn_ack_reg;
    assign send_signal = send_reg;
    assign frame_base  = frame_base_reg;
    // While a job is active the arbiter's last winner is the current owner
    assign owner       = busy_reg & last_grant;
    assign busy        = busy_reg;
    assign frame_done  = frame_done_reg;
    assign aborted     = aborted_reg;

endmodule

// File: tb/tb_bpsk_frame_sched.sv
// Directed bench for bpsk_frame_sched with a 64-bit frame and 4-bit gap.
module tb_bpsk_frame_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        baud_tick;
    logic        host_req;
    logic        host_slot;
    logic [7:0]  host_repeat;
    logic        bcn_req;
    logic        bcn_slot;
    logic        abort;
    logic        host_ack;
    logic        bcn_ack;
    logic        send_signal;
    logic [31:0] frame_base;
    logic        owner;
    logic        busy;
    logic        frame_done;
    logic        aborted;

    int n_chk = 0;
    int n_bad = 0;

    // event counters sampled on the active edge
    int n_done = 0;
    int n_abt  = 0;
    int n_hack = 0;
    int n_back = 0;
    int n_stk  = 0;
    int n_win  = 0;
    logic prev_send = 1'b0;

    int s_done, s_abt, s_hack, s_back, s_stk, s_win;

    bpsk_frame_sched #(
        .WORD_BITS   (32),
        .FRAME_WORDS (2),
        .GAP_BITS    (4),
        .SLOT_STRIDE (152),
        .ADDR_WIDTH  (32),
        .REP_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_tick   (baud_tick),
        .host_req    (host_req),
        .host_slot   (host_slot),
        .host_repeat (host_repeat),
        .bcn_req     (bcn_req),
        .bcn_slot    (bcn_slot),
        .abort       (abort),
        .host_ack    (host_ack),
        .bcn_ack     (bcn_ack),
        .send_signal (send_signal),
        .frame_base  (frame_base),
        .owner       (owner),
        .busy        (busy),
        .frame_done  (frame_done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) n_done <= n_done + 1;
        if (aborted)    n_abt  <= n_abt + 1;
        if (host_ack)   n_hack <= n_hack + 1;
        if (bcn_ack)    n_back <= n_back + 1;
        if (baud_tick && send_signal) n_stk <= n_stk + 1;
        if (send_signal && !prev_send) n_win <= n_win + 1;
        prev_send <= send_signal;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // each tick is one strobe cycle followed by one quiet cycle
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            baud_tick = 1'b1;
            step();
            baud_tick = 1'b0;
            step();
        end
    endtask

    task automatic snap();
        s_done = n_done; s_abt = n_abt; s_hack = n_hack;
        s_back = n_back; s_stk = n_stk; s_win  = n_win;
    endtask

    initial begin
        rst_n = 1'b0; baud_tick = 1'b0; host_req = 1'b0; host_slot = 1'b0;
        host_repeat = 8'd1; bcn_req = 1'b0; bcn_slot = 1'b0; abort = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_send", send_signal, 0);
        chk("rst_base", frame_base, 0);
        chk("rst_owner", owner, 0);

        // tie from reset: host first, then beacon on the first IDLE cycle
        host_slot = 1'b0; bcn_slot = 1'b1; host_repeat = 8'd1;
        host_req = 1'b1; bcn_req = 1'b1;
        step();
        chk("tie1_hack", host_ack, 1);
        chk("tie1_back", bcn_ack, 0);
        chk("tie1_owner", owner, 0);
        chk("tie1_base", frame_base, 0);
        host_req = 1'b0;
        tick_n(1 + 64 + 4);
        chk("tie1_bcn_ack", bcn_ack, 1);
        chk("tie1_bcn_owner", owner, 1);
        chk("tie1_bcn_base", frame_base, 152);
        bcn_req = 1'b0;
        tick_n(1 + 64 + 4);
        chk("tie1_idle", busy, 0);

        // second tie alternates back to host; beacon drops before its ack
        snap();
        host_slot = 1'b1; bcn_slot = 1'b0;
        host_req = 1'b1; bcn_req = 1'b1;
        step();
        chk("tie2_hack", host_ack, 1);
        chk("tie2_base", frame_base, 152);
        host_req = 1'b0; bcn_req = 1'b0;
        tick_n(1 + 64 + 4);
        chk("tie2_no_bcn", n_back - s_back, 0);

        // single host frame, slot 1
        snap();
        host_slot = 1'b1; host_repeat = 8'd1; host_req = 1'b1;
        step();
        chk("one_hack", host_ack, 1);
        chk("one_base", frame_base, 152);
        chk("one_busy", busy, 1);
        host_req = 1'b0;
        step();
        chk("one_hack_pulse", host_ack, 0);
        tick_n(1 + 64 + 3);
        chk("one_busy_gap", busy, 1);
        chk("one_send_gap", send_signal, 0);
        tick_n(1);
        chk("one_busy_end", busy, 0);
        chk("one_done_cnt", n_done - s_done, 1);
        chk("one_send_ticks", n_stk - s_stk, 64);
        chk("one_hack_cnt", n_hack - s_hack, 1);

        // repeat 3
        snap();
        host_slot = 1'b0; host_repeat = 8'd3; host_req = 1'b1;
        step();
        host_req = 1'b0;
        tick_n(1 + 64 + 2);
        chk("rep3_gap_send", send_signal, 0);
        chk("rep3_gap_busy", busy, 1);
        tick_n(2 + 64 + 4 + 64 + 4);
        chk("rep3_busy_end", busy, 0);
        chk("rep3_done_cnt", n_done - s_done, 3);
        chk("rep3_windows", n_win - s_win, 3);
        chk("rep3_send_ticks", n_stk - s_stk, 192);

        // repeat 0 behaves as 1
        snap();
        host_repeat = 8'd0; host_req = 1'b1;
        step();
        host_req = 1'b0;
        tick_n(1 + 64 + 4);
        chk("rep0_busy_end", busy, 0);
        chk("rep0_done_cnt", n_done - s_done, 1);
        chk("rep0_windows", n_win - s_win, 1);

        // abort on tick 30 of frame 1 of a repeat-3 job; beacon pending
        snap();
        host_slot = 1'b1; host_repeat = 8'd3; host_req = 1'b1; bcn_slot = 1'b0;
        step();
        host_req = 1'b0; bcn_req = 1'b1;
        tick_n(1 + 29);
        chk("ab30_bcn_wait", n_back - s_back, 0);
        baud_tick = 1'b1; abort = 1'b1;
        step();
        baud_tick = 1'b0; abort = 1'b0;
        chk("ab30_send", send_signal, 0);
        chk("ab30_aborted", aborted, 1);
        chk("ab30_busy", busy, 0);
        chk("ab30_done", frame_done, 0);
        step();
        chk("ab30_bcn_ack", bcn_ack, 1);
        chk("ab30_bcn_owner", owner, 1);
        chk("ab30_bcn_base", frame_base, 0);
        bcn_req = 1'b0;
        step();
        chk("ab30_done_cnt", n_done - s_done, 0);
        chk("ab30_abt_cnt", n_abt - s_abt, 1);
        tick_n(1 + 64 + 4);
        chk("ab30_bcn_end", busy, 0);

        // abort coincident with the 64th tick; host held while beacon busy
        snap();
        bcn_slot = 1'b1; bcn_req = 1'b1;
        step();
        chk("ab64_bcn_ack", bcn_ack, 1);
        bcn_req = 1'b0;
        host_slot = 1'b0; host_repeat = 8'd2; host_req = 1'b1;
        tick_n(1 + 63);
        chk("ab64_host_wait", n_hack - s_hack, 0);
        baud_tick = 1'b1; abort = 1'b1;
        step();
        baud_tick = 1'b0; abort = 1'b0;
        chk("ab64_aborted", aborted, 1);
        chk("ab64_done", frame_done, 0);
        chk("ab64_busy", busy, 0);
        step();
        chk("ab64_host_ack", host_ack, 1);
        chk("ab64_host_owner", owner, 0);
        chk("ab64_host_base", frame_base, 0);
        host_req = 1'b0;
        tick_n(1 + 64 + 4 + 64 + 4);
        chk("ab64_host_end", busy, 0);
        chk("ab64_done_cnt", n_done - s_done, 2);

        // abort while idle is ignored
        snap();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        chk("idle_abort", n_abt - s_abt, 0);
        chk("idle_abort_busy", busy, 0);

        // asynchronous reset in the middle of a frame
        host_slot = 1'b1; host_repeat = 8'd3; host_req = 1'b1;
        step();
        host_req = 1'b0;
        tick_n(1 + 10);
        chk("pre_rst_send", send_signal, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_send", send_signal, 0);
        chk("arst_busy", busy, 0);
        chk("arst_owner", owner, 0);
        chk("arst_base", frame_base, 0);
        chk("arst_acks", {host_ack, bcn_ack}, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);

        // arbiter history was reset too: the tie goes to host again
        host_slot = 1'b0; bcn_slot = 1'b1; host_repeat = 8'd1;
        host_req = 1'b1; bcn_req = 1'b1;
        step();
        chk("post_rst_tie_hack", host_ack, 1);
        chk("post_rst_tie_back", bcn_ack, 0);
        host_req = 1'b0; bcn_req = 1'b0;
        tick_n(1 + 64 + 4);
        chk("post_rst_end", busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
